// File: rtl/conv_pkg.sv
// Shared definitions for the convolution pixel streamer.
// Holds the streamer FSM state encoding, default frame geometry and
// pixel width, and a helper that sizes counters for a given maximum.
package conv_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

  localparam int INPUT_BITS_DEF    = 16;
  localparam int IMAGE_WIDTH_DEF   = 12;
  localparam int N_PIX             = IMAGE_WIDTH_DEF * IMAGE_WIDTH_DEF;
  localparam int DRAIN_TIMEOUT_DEF = 64;

  // Bits needed to hold 0..max; never less than one bit.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/conv_frame_ram.sv
// Frame store for the pixel streamer: single-port synchronous RAM.
// Ports:
//   clk, reset  - clock, synchronous active-low reset (clears read register only)
//   we          - write strobe; a write suppresses the read on that edge
//   rd_clr      - zero the read register instead of reading
//   addr        - shared read/write address
//   wdata       - write data
//   q           - registered read data (drives the stream pixel directly)
module conv_frame_ram #(
  parameter int addr_bits  = 8,
  parameter int input_bits = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  rd_clr,
  input  logic [addr_bits-1:0]  addr,
  input  logic [input_bits-1:0] wdata,
  output logic [input_bits-1:0] q
);

  logic [input_bits-1:0] mem [2**addr_bits];

  // Storage is deliberately left out of reset so a frame survives an abort.
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  // Read register doubles as the pixel output, so clearing it keeps
  // pixel_out at zero on every non-valid cycle.
  always_ff @(posedge clk)
    if (!reset || rd_clr) q <= '0;
    else if (!we)         q <= mem[addr];

endmodule

// File: rtl/conv_frame_streamer.sv
// Transmit side of the convolution pixel stream.
// Stores one image_width x image_width frame written by the host, and on
// start: pulses conv_clear, streams the frame in raster order on
// pixel_out/valid (optionally with an idle cycle every gap_every pixels),
// then waits up to drain_timeout cycles for conv_finish.
// Ports:
//   clk, reset              - clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data   - host frame write port (honoured only when idle)
//   start                   - begin streaming the stored frame
//   conv_finish             - engine finished flag
//   pixel_out/valid         - pixel stream to the engine
//   conv_clear              - one-cycle engine clear ahead of the stream
//   busy, done, err         - status: not idle, end-of-frame pulse, sticky timeout
module conv_frame_streamer
  import conv_pkg::*;
#(
  parameter int input_bits    = INPUT_BITS_DEF,
  parameter int image_width   = IMAGE_WIDTH_DEF,
  parameter int addr_bits     = 8,
  parameter int gap_every     = 0,
  parameter int drain_timeout = DRAIN_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [addr_bits-1:0]  wr_addr,
  input  logic [input_bits-1:0] wr_data,
  input  logic                  start,
  input  logic                  conv_finish,
  output logic [input_bits-1:0] pixel_out,
  output logic                  valid,
  output logic                  conv_clear,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int NP = image_width * image_width;
  localparam int GW = cnt_w(gap_every);
  localparam int TW = cnt_w(drain_timeout);
  localparam logic [addr_bits-1:0] LAST_IDX = addr_bits'(NP - 1);
  localparam logic [GW-1:0]        GAP_N    = GW'(gap_every);
  localparam logic [TW-1:0]        TMO_N    = TW'(drain_timeout);

  state_t                state, state_n;
  logic [addr_bits-1:0]  pix_idx, pix_idx_n, pix_idx_inc;
  logic [GW-1:0]         gap_cnt, gap_cnt_n, gap_inc;
  logic [TW-1:0]         to_cnt, to_cnt_n, to_inc;
  logic                  fetch, err_n, ram_we;
  logic [addr_bits-1:0]  ram_addr;

  // pix_idx is the next address to fetch; it wraps to 0 after the last
  // pixel, so "valid while pix_idx==0 in STREAM" means the final pixel is out.
  assign pix_idx_inc = (pix_idx == LAST_IDX) ? '0 : pix_idx + 1'b1;
  assign gap_inc     = gap_cnt + 1'b1;
  assign to_inc      = to_cnt + 1'b1;

  always_comb begin
    state_n   = state;
    pix_idx_n = pix_idx;
    gap_cnt_n = gap_cnt;
    to_cnt_n  = to_cnt;
    fetch     = 1'b0;
    err_n     = err;
    unique case (state)
      IDLE:
        if (start) begin
          state_n   = CLEAR;
          pix_idx_n = '0;
          gap_cnt_n = '0;
          to_cnt_n  = '0;
        end
      CLEAR: begin
        // Prefetch pixel 0 so it is on pixel_out the first STREAM cycle.
        fetch     = 1'b1;
        pix_idx_n = pix_idx_inc;
        state_n   = STREAM;
      end
      STREAM:
        if (valid && pix_idx == '0) begin
          state_n  = DRAIN;
          to_cnt_n = '0;
        end else if (valid && gap_every != 0 && gap_inc == GAP_N) begin
          gap_cnt_n = '0;
        end else begin
          fetch     = 1'b1;
          pix_idx_n = pix_idx_inc;
          if (valid) gap_cnt_n = gap_inc;
        end
      DRAIN:
        if (conv_finish) begin
          state_n = DONE;
        end else begin
          to_cnt_n = to_inc;
          if (to_inc == TMO_N) begin
            err_n   = 1'b1;
            state_n = DONE;
          end
        end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state_n == CLEAR) err_n = 1'b0;
  end

  // Same-cycle write+start commits in IDLE; the CLEAR-cycle read sees it.
  assign ram_we   = reset && (state == IDLE) && wr_en && (32'(wr_addr) < NP);
  assign ram_addr = (state == IDLE) ? wr_addr : pix_idx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      pix_idx    <= '0;
      gap_cnt    <= '0;
      to_cnt     <= '0;
      valid      <= 1'b0;
      conv_clear <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      pix_idx    <= pix_idx_n;
      gap_cnt    <= gap_cnt_n;
      to_cnt     <= to_cnt_n;
      valid      <= fetch;
      conv_clear <= (state_n == CLEAR);
      busy       <= (state_n != IDLE);
      done       <= (state_n == DONE);
      err        <= err_n;
    end
  end

  conv_frame_ram #(
    .addr_bits  (addr_bits),
    .input_bits (input_bits)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .we     (ram_we),
    .rd_clr (!fetch),
    .addr   (ram_addr),
    .wdata  (wr_data),
    .q      (pixel_out)
  );

endmodule

// File: tb/tb_conv_frame_streamer.sv
// Directed bench: dut_a streams without gaps, dut_b with gap_every=12.
// Both share all inputs. Outputs are sampled 1 time unit after the edge.
module tb_conv_frame_streamer;
  import conv_pkg::*;

  localparam int NP = N_PIX;
  localparam int AB = 8;
  localparam int IB = 16;

  logic          clk = 1'b0, reset = 1'b0, wr_en = 1'b0, start = 1'b0, conv_finish = 1'b0;
  logic [AB-1:0] wr_addr = '0;
  logic [IB-1:0] wr_data = '0;
  logic [IB-1:0] pix_a, pix_b;
  logic          val_a, clr_a, busy_a, done_a, err_a;
  logic          val_b, clr_b, busy_b, done_b, err_b;

  always #5 clk = ~clk;

  conv_frame_streamer #(.input_bits(IB), .image_width(12), .addr_bits(AB),
                        .gap_every(0), .drain_timeout(64)) dut_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .conv_finish(conv_finish), .pixel_out(pix_a), .valid(val_a),
    .conv_clear(clr_a), .busy(busy_a), .done(done_a), .err(err_a));

  conv_frame_streamer #(.input_bits(IB), .image_width(12), .addr_bits(AB),
                        .gap_every(12), .drain_timeout(64)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .conv_finish(conv_finish), .pixel_out(pix_b), .valid(val_b),
    .conv_clear(clr_b), .busy(busy_b), .done(done_b), .err(err_b));

  typedef struct {
    int          rel;
    bit          sel;   // 0 = dut_a, 1 = dut_b
    logic        clr, val, busy, done, err;
    logic [15:0] pix;
  } vec_t;

  vec_t tab[$];
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic add(input int rel, input bit sel, input logic c, v, b, d, e,
                     input logic [15:0] p);
    vec_t x;
    x.rel = rel; x.sel = sel; x.clr = c; x.val = v; x.busy = b;
    x.done = d; x.err = e; x.pix = p;
    tab.push_back(x);
  endtask

  task automatic mon(input logic v, input logic [15:0] p, input logic d, input int rel,
                     input logic [15:0] exp5,
                     inout int idx, inout int bad, inout int gaps, inout int first,
                     inout int last, inout int dcnt, inout int drel);
    logic [15:0] e;
    if (v === 1'b1) begin
      e = (idx == 5) ? exp5 : 16'(idx);
      if (idx >= NP || p !== e) bad++;
      if (idx == 0) first = rel;
      idx++;
      if (idx == NP) last = rel;
    end else begin
      if (p !== 16'd0) bad++;
      if (idx > 0 && idx < NP) gaps++;
    end
    if (d === 1'b1) begin
      dcnt++;
      if (drel < 0) drel = rel;
    end
  endtask

  // Start at rel 0, run nrel cycles. conv_finish high for rel in [fin_lo,fin_hi];
  // addr 5 <= -7 written at wr_rel; stray start at spur_rel; reset low at abort_rel.
  task automatic run(input string tag, input int nrel, input int fin_lo, input int fin_hi,
                     input int wr_rel, input int spur_rel, input int abort_rel,
                     input logic [15:0] exp5, input int done_a_rel, input int done_b_rel,
                     input logic exp_err);
    int ia = 0, ba = 0, ga = 0, fa = -1, la = -1, da = 0, ra = -1;
    int ib = 0, bb = 0, gb = 0, fb = -1, lb = -1, db = 0, rb = -1;
    start = 1'b1;
    conv_finish = (fin_lo <= 0 && fin_hi >= 0);
    if (wr_rel == 0) begin wr_en = 1'b1; wr_addr = 8'd5; wr_data = 16'hFFF9; end
    for (int rel = 1; rel <= nrel; rel++) begin
      tick();
      start = 1'b0; wr_en = 1'b0; reset = 1'b1;
      foreach (tab[i]) if (tab[i].rel == rel) begin
        string s;
        s = $sformatf("%s_%s@%0d", tag, tab[i].sel ? "b" : "a", rel);
        chk({s, "_clr"},  tab[i].sel ? clr_b  : clr_a,  tab[i].clr);
        chk({s, "_val"},  tab[i].sel ? val_b  : val_a,  tab[i].val);
        chk({s, "_busy"}, tab[i].sel ? busy_b : busy_a, tab[i].busy);
        chk({s, "_done"}, tab[i].sel ? done_b : done_a, tab[i].done);
        chk({s, "_err"},  tab[i].sel ? err_b  : err_a,  tab[i].err);
        chk({s, "_pix"},  tab[i].sel ? pix_b  : pix_a,  tab[i].pix);
      end
      mon(val_a, pix_a, done_a, rel, exp5, ia, ba, ga, fa, la, da, ra);
      mon(val_b, pix_b, done_b, rel, exp5, ib, bb, gb, fb, lb, db, rb);
      conv_finish = (rel >= fin_lo && rel <= fin_hi);
      if (rel == wr_rel)    begin wr_en = 1'b1; wr_addr = 8'd5; wr_data = 16'hFFF9; end
      if (rel == spur_rel)  start = 1'b1;
      if (rel == abort_rel) reset = 1'b0;
    end
    conv_finish = 1'b0;
    if (abort_rel < 0) begin
      chk({tag, "_a_count"}, ia, NP);        chk({tag, "_b_count"}, ib, NP);
      chk({tag, "_a_order"}, ba, 0);         chk({tag, "_b_order"}, bb, 0);
      chk({tag, "_a_gaps"},  ga, 0);         chk({tag, "_b_gaps"},  gb, 11);
      chk({tag, "_a_first"}, fa, 2);         chk({tag, "_b_first"}, fb, 2);
      chk({tag, "_a_last"},  la, 145);       chk({tag, "_b_last"},  lb, 156);
      chk({tag, "_a_done_rel"}, ra, done_a_rel);
      chk({tag, "_b_done_rel"}, rb, done_b_rel);
      chk({tag, "_a_done_len"}, da, 1);      chk({tag, "_b_done_len"}, db, 1);
      chk({tag, "_a_err"}, err_a, exp_err);  chk({tag, "_b_err"}, err_b, exp_err);
      chk({tag, "_a_idle"}, busy_a, 0);      chk({tag, "_b_idle"}, busy_b, 0);
    end
    tab.delete();
    tick(); tick();
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_a_outs", {pix_a, val_a, clr_a, busy_a, done_a, err_a}, 0);
    chk("rst_b_outs", {pix_b, val_b, clr_b, busy_b, done_b, err_b}, 0);
    reset = 1'b1;
    tick();
    chk("rst_rel_busy", busy_a, 0);

    // Load ramp
    for (int a = 0; a < NP; a++) begin
      wr_en = 1'b1; wr_addr = AB'(a); wr_data = IB'(a);
      tick();
      chk("load_busy", busy_a | busy_b, 0);
    end
    wr_en = 1'b0;
    tick();

    // Run 1: finish 14 cycles after last pixel, stray write and start mid-stream
    add(1,   0, 1, 0, 1, 0, 0, 16'd0);
    add(2,   0, 0, 1, 1, 0, 0, 16'd0);
    add(3,   0, 0, 1, 1, 0, 0, 16'd1);
    add(7,   0, 0, 1, 1, 0, 0, 16'd5);
    add(100, 0, 0, 1, 1, 0, 0, 16'd98);
    add(145, 0, 0, 1, 1, 0, 0, 16'd143);
    add(146, 0, 0, 0, 1, 0, 0, 16'd0);
    add(159, 0, 0, 0, 1, 0, 0, 16'd0);
    add(160, 0, 0, 0, 1, 1, 0, 16'd0);
    add(161, 0, 0, 0, 0, 0, 0, 16'd0);
    add(1,   1, 1, 0, 1, 0, 0, 16'd0);
    add(13,  1, 0, 1, 1, 0, 0, 16'd11);
    add(14,  1, 0, 0, 1, 0, 0, 16'd0);
    add(15,  1, 0, 1, 1, 0, 0, 16'd12);
    add(156, 1, 0, 1, 1, 0, 0, 16'd143);
    add(157, 1, 0, 0, 1, 0, 0, 16'd0);
    run("fin14", 165, 159, 160, 3, 50, -1, 16'd5, 160, 160, 1'b0);

    // Run 2: conv_finish never arrives -> timeout
    add(209, 0, 0, 0, 1, 0, 0, 16'd0);
    add(210, 0, 0, 0, 1, 1, 1, 16'd0);
    add(211, 0, 0, 0, 0, 0, 1, 16'd0);
    add(221, 1, 0, 0, 1, 1, 1, 16'd0);
    run("tmo", 225, -1, -1, -1, -1, -1, 16'd5, 210, 221, 1'b1);

    // Run 3: err cleared by CLEAR, then reset mid-stream after pixel 50
    chk("tmo_err_idle", err_a, 1);
    add(1,  0, 1, 0, 1, 0, 0, 16'd0);
    add(1,  1, 1, 0, 1, 0, 0, 16'd0);
    add(52, 0, 0, 1, 1, 0, 0, 16'd50);
    add(52, 1, 0, 1, 1, 0, 0, 16'd47);
    add(53, 0, 0, 0, 0, 0, 0, 16'd0);
    add(53, 1, 0, 0, 0, 0, 0, 16'd0);
    add(56, 0, 0, 0, 0, 0, 0, 16'd0);
    run("abort", 56, -1, -1, -1, -1, 52, 16'd5, -1, -1, 1'b0);

    // Run 4: write+start same cycle; finish already high at DRAIN entry
    add(7,   0, 0, 1, 1, 0, 0, 16'hFFF9);
    add(146, 0, 0, 0, 1, 0, 0, 16'd0);
    add(147, 0, 0, 0, 1, 1, 0, 16'd0);
    add(148, 0, 0, 0, 0, 0, 0, 16'd0);
    add(158, 1, 0, 0, 1, 1, 0, 16'd0);
    run("wrstart", 162, 0, 200, 0, -1, -1, 16'hFFF9, 147, 158, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_frame_streamer.md
Name: conv_frame_streamer

Overview:
- Transmit side of the convolution pixel stream. Holds one image_width x image_width frame in local memory, loaded by the host over a simple write port.
- On start, pulses a clear to the downstream conv engine, streams the frame in raster order as pixel/valid, then waits for the engine's finish flag.
- Sits between the host/DMA loader and the 5x5 conv engine. Its pixel_out/valid/conv_clear drive the engine's input_port/valid/reset; the engine's finish returns as conv_finish.

Parameters:
- input_bits, 16, pixel width (signed).
- image_width, 12, frame side; the frame holds image_width*image_width pixels.
- addr_bits, 8, memory address width; must satisfy 2**addr_bits >= image_width*image_width.
- gap_every, 0, insert one idle (valid=0) cycle after every gap_every pixels; 0 = no gaps.
- drain_timeout, 64, maximum cycles to wait for conv_finish after the last pixel.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- wr_en  in  1  frame memory write strobe
- wr_addr  in  addr_bits  pixel index (row*image_width+col)
- wr_data  in  input_bits  signed pixel
- start  in  1  begin streaming the stored frame
- conv_finish  in  1  finish flag from the conv engine
- pixel_out  out  input_bits  signed pixel to the engine
- valid  out  1  pixel_out qualifier
- conv_clear  out  1  active-high clear to the engine
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of frame
- err  out  1  sticky drain-timeout flag

Behaviour:
- All outputs are registered.
- Reset (reset==0 at clk edge) gives: state=IDLE, pixel_out=0, valid=0, conv_clear=0, busy=0, done=0, err=0, all counters=0. Frame memory is not cleared.
- Reset mid-stream aborts immediately; no further valid cycles are emitted.
- Memory writes:
  - Accepted only in IDLE.
  - wr_en in any other state is ignored.
  - wr_addr >= image_width^2 is ignored.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE -> CLEAR:
  - Taken when start==1.
  - When wr_en and start occur in the same cycle, the write commits first and the new data is streamed.
  - start outside IDLE is ignored.
- CLEAR:
  - Lasts exactly one cycle with conv_clear=1 and valid=0.
  - Issues a synchronous memory read of address 0 (prefetch).
  - err clears here.
- STREAM:
  - The pixel at index k is presented with valid=1.
  - With gap_every=0: pixels 0..N-1 (N=image_width^2) are on consecutive cycles; the first valid is the cycle after CLEAR, so STREAM lasts exactly N cycles.
  - With gap_every=G>0: after every G valid pixels, one cycle has valid=0. pixel_out=0 and the address holds during the gap. No gap follows the final pixel.
  - pixel_out=0 whenever valid=0.
  - Transition to DRAIN after pixel N-1 is issued.
- DRAIN:
  - valid=0. A timeout counter increments each cycle.
  - conv_finish==1 -> DONE.
  - If the counter reaches drain_timeout first: err=1 -> DONE.
  - A conv_finish already high on DRAIN entry is accepted on the first DRAIN cycle.
- DONE:
  - Lasts one cycle with done=1, then -> IDLE.
  - busy falls in the same cycle that done falls.
- Counters:
  - Pixel index counter is addr_bits wide and wraps to 0 after N-1.
  - Gap counter is sized for gap_every.
  - Timeout counter is sized for drain_timeout.
- No arithmetic on pixel data; it passes through unchanged, sign preserved.

Decomposition:
- Shared package (conv_pkg) holds:
  - the FSM state enum (IDLE/CLEAR/STREAM/DRAIN/DONE);
  - N_PIX = image_width*image_width;
  - the default pixel width;
  - the default drain timeout.
- One natural sub-module: conv_frame_ram. It is a single-port synchronous RAM of depth 2**addr_bits and width input_bits, with a registered read and write taking priority. The read address is muxed between the host port in IDLE and the stream counter otherwise.

Test Plan:
- Load ramp, wr_data=addr for 0..143; start at cycle T, gap_every=0 -> conv_clear=1 at T+1; valid=1 for T+2..T+145 with pixel_out=0..143; DRAIN from T+146.
- Above, with conv_finish raised 14 cycles after the last pixel -> done pulses one cycle later; busy then 0, err=0.
- gap_every=12, ramp frame -> 144 valid pixels in order, 11 single-cycle gaps (one after every 12 pixels, none after the last), STREAM lasts 155 cycles.
- conv_finish held 0, drain_timeout=64 -> err=1 and done pulse 64 cycles into DRAIN; a subsequent start clears err in CLEAR.
- Mid-stream (after pixel 50): reset=0 for one cycle -> next cycle valid=0, busy=0, state IDLE; a new start restreams from pixel 0 with memory intact.
- wr_en to addr 5 (data -7) during STREAM -> ignored, stream unchanged; the same write in IDLE, in the same cycle as start -> pixel 5 streams as -7 (0xFFF9).
